// File: rtl/tmp_pkg.sv
// Shared constants and helpers for the TMP staging queue.
// Default geometry and the ceiling-log2 used to size pointers and the occupancy count.
package tmp_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Ceiling log2, never below 1 so that a single-entry queue still gets a 1-bit pointer.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tmp_mem.sv
// Entry storage for the TMP queue: one synchronous write port, one asynchronous read port.
module tmp_mem
    import tmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the queue's count, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tmp_queue.sv
// Circular staging queue of TMP values with sticky overflow/underflow flags and a bus1 override.
// Head/tail pointers, occupancy count and error flags live here; storage lives in tmp_mem.
module tmp_queue
    import tmp_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic             e,
    input  logic             bus1,
    input  logic [WIDTH-1:0] t_in,
    output logic [WIDTH-1:0] t_out,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             udf
);

    localparam int            PW       = clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_udf;

    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [WIDTH-1:0] w_rd_data;
    logic [WIDTH-1:0] w_t_out;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A pop frees the slot the push needs, so a full queue still accepts s when e is also set.
    assign w_do_pop  = e && !w_empty;
    assign w_do_push = s && (!w_full || w_do_pop);

    tmp_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_do_push && !reset),
        .i_waddr (r_tail),
        .i_wdata (t_in),
        .i_raddr (r_head),
        .o_rdata (w_rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_do_push) r_tail <= (r_tail == LAST_PTR) ? '0 : r_tail + PW'(1);
            if (w_do_pop)  r_head <= (r_head == LAST_PTR) ? '0 : r_head + PW'(1);

            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase

            if (s && !e && w_full) r_ovf <= 1'b1;
            if (e && w_empty)      r_udf <= 1'b1;
        end
    end

    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        w_t_out = '0;
        if (bus1)          w_t_out = WIDTH'(1);
        else if (!w_empty) w_t_out = w_rd_data;
    end

    assign t_out = w_t_out;
    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;
    assign ovf   = r_ovf;
    assign udf   = r_udf;

endmodule

// File: tb/tb_tmp_queue.sv
// Scoreboard bench for tmp_queue (WIDTH=8, DEPTH=4): directed stimulus queues expected pops,
// a negedge monitor compares t_out against them whenever the DUT retires an entry.
module tb_tmp_queue;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s = 1'b0;
    logic       e = 1'b0;
    logic       bus1 = 1'b0;
    logic [7:0] t_in = 8'h00;
    logic [7:0] t_out;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       udf;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb [$];

    tmp_queue #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .e     (e),
        .bus1  (bus1),
        .t_in  (t_in),
        .t_out (t_out),
        .count (count),
        .full  (full),
        .empty (empty),
        .ovf   (ovf),
        .udf   (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs are held from just after one rising edge to just after the next.
    task automatic op(input logic ps, input logic pe, input logic [7:0] d);
        s = ps; e = pe; t_in = d;
        @(posedge clk); #1;
        s = 1'b0; e = 1'b0; t_in = 8'h00;
    endtask

    task automatic push(input logic [7:0] d);
        sb.push_back(d);
        op(1'b1, 1'b0, d);
    endtask

    task automatic pop();
        op(1'b0, 1'b1, 8'h00);
    endtask

    task automatic do_reset(input logic with_push, input logic [7:0] d);
        reset = 1'b1; s = with_push; t_in = d;
        @(posedge clk); #1;
        reset = 1'b0; s = 1'b0; t_in = 8'h00;
        sb.delete();
    endtask

    // Monitor: every retired entry must match the oldest expected value.
    always @(negedge clk) begin
        if (!reset && e && !empty) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no pop", t_out);
            end else begin
                logic [7:0] exp_v;
                exp_v = sb.pop_front();
                if (!bus1) check("pop_data", {56'h0, t_out}, {56'h0, exp_v});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full",  full,  0);
        check("rst_ovf",   ovf,   0);
        check("rst_udf",   udf,   0);
        check("rst_t_out", t_out, 8'h00);

        // Fill, with a write-through probe on the first push
        sb.push_back(8'h11);
        s = 1'b1; t_in = 8'h11;
        #1;
        check("no_write_through", t_out, 8'h00);
        @(posedge clk); #1;
        s = 1'b0; t_in = 8'h00;
        check("push_latency", t_out, 8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        check("fill_count", count, 4);
        check("fill_full",  full,  1);
        check("fill_t_out", t_out, 8'h11);
        check("fill_ovf",   ovf,   0);

        // Overflow: dropped write, sticky flag, contents intact
        op(1'b1, 1'b0, 8'h55);
        check("ovf_set",   ovf,   1);
        check("ovf_count", count, 4);
        repeat (4) pop();
        check("drain_empty", empty, 1);
        check("ovf_sticky",  ovf,   1);
        check("drain_udf",   udf,   0);

        // Wrap-around: pointers cycle through all entries more than twice
        for (int i = 0; i < 10; i++) begin
            push(8'(i));
            pop();
        end
        check("wrap_count", count, 0);

        // Simultaneous push/pop on an empty queue
        do_reset(1'b0, 8'h00);
        sb.push_back(8'hA5);
        op(1'b1, 1'b1, 8'hA5);
        check("se_empty_count", count, 1);
        check("se_empty_t_out", t_out, 8'hA5);
        check("se_empty_udf",   udf,   1);

        // Simultaneous push/pop on a full queue
        push(8'hB1);
        push(8'hC2);
        push(8'hD3);
        check("pre_se_full", full, 1);
        sb.push_back(8'hE4);
        op(1'b1, 1'b1, 8'hE4);
        check("se_full_count", count, 4);
        check("se_full_head",  t_out, 8'hB1);
        check("se_full_ovf",   ovf,   0);
        repeat (4) pop();

        // bus1 override
        do_reset(1'b0, 8'h00);
        push(8'h7E);
        bus1 = 1'b1;
        #1;
        check("bus1_on",    t_out, 8'h01);
        check("bus1_count", count, 1);
        bus1 = 1'b0;
        #1;
        check("bus1_off", t_out, 8'h7E);
        pop();
        bus1 = 1'b1;
        #1;
        check("bus1_empty", t_out, 8'h01);
        bus1 = 1'b0;

        // Reset mid-operation beats a simultaneous push
        pop();
        check("pre_rst_udf", udf, 1);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("pre_rst_count", count, 3);
        do_reset(1'b1, 8'h99);
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_ovf",   ovf,   0);
        check("mid_rst_udf",   udf,   0);
        check("mid_rst_t_out", t_out, 8'h00);
        push(8'h5A);
        check("post_rst_t_out", t_out, 8'h5A);
        check("post_rst_count", count, 1);
        pop();

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
